// File: rtl/mcu_bus_pkg.sv
// ============================================================
// mcu_bus_pkg : shared widths, constants and FSM encoding
// Rev 1.0
// ============================================================
`default_nettype none

package mcu_bus_pkg;

    localparam int DEF_ADDR_W = 21;
    localparam int DEF_DATA_W = 16;

    localparam logic [15:0] DEAD_WORD = 16'hDEAD;

    localparam logic [1:0] ECC_NONE = 2'd0;
    localparam logic [1:0] ECC_HAM  = 2'd1;
    localparam logic [1:0] ECC_TMR  = 2'd2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WR_ACTIVE = 3'd1;
    localparam state_t ST_WR_ISSUE  = 3'd2;
    localparam state_t ST_RD_ISSUE  = 3'd3;
    localparam state_t ST_RD_WAIT   = 3'd4;
    localparam state_t ST_RD_DRIVE  = 3'd5;
    localparam state_t ST_WAIT_END  = 3'd6;

endpackage

`default_nettype wire

// File: rtl/strobe_sync.sv
// ============================================================
// strobe_sync : 2-FF synchronizer plus SETTLE-cycle stability filter
// Rev 1.0
// ============================================================
`default_nettype none

module strobe_sync #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_stable
);

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Strobes are active-low, so every stage resets to the inactive (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(SETTLE - 1)) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sync   = r_sync;
    assign o_stable = r_stable;

endmodule

`default_nettype wire

// File: rtl/mcu_bus_capture.sv
// ============================================================
// mcu_bus_capture : async MCU SRAM bus to valid/ready request front end
// Rev 1.0
// ============================================================
`default_nettype none

module mcu_bus_capture
    import mcu_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETTLE     = 2,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mcu_cs_n,
    input  logic              mcu_we_n,
    input  logic              mcu_oe_n,
    input  logic              mcu_lb_n,
    input  logic              mcu_ub_n,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [DATA_W-1:0] mcu_wdata,
    output logic [DATA_W-1:0] mcu_rdata,
    output logic              mcu_rdata_oe,
    input  logic [1:0]        ecc_sel,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [1:0]        req_be,
    output logic [1:0]        req_ecc,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int N_STB = 5;
    localparam int TO_W  = $clog2(RD_TIMEOUT + 1);

    logic [N_STB-1:0] w_raw;
    logic [N_STB-1:0] w_sync;
    logic [N_STB-1:0] w_stable;
    logic             w_cs_st;
    logic             w_we_st;
    logic             w_oe_st;
    logic             w_unused_stb;

    state_t            r_state;
    logic [ADDR_W-1:0] r_sh_addr;
    logic [DATA_W-1:0] r_sh_wdata;
    logic [1:0]        r_sh_be;
    logic [1:0]        r_sh_ecc;
    logic              r_we_st_d;
    logic              r_req_valid;
    logic              r_req_write;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic [1:0]        r_req_be;
    logic [1:0]        r_req_ecc;
    logic [DATA_W-1:0] r_rdata;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_err_timeout;
    logic              r_err_overrun;

    // Bit order: 0 CS, 1 WE, 2 OE, 3 LB, 4 UB.
    assign w_raw = {mcu_ub_n, mcu_lb_n, mcu_oe_n, mcu_we_n, mcu_cs_n};

    generate
        for (genvar gi = 0; gi < N_STB; gi++) begin : g_sync
            strobe_sync #(
                .SETTLE  (SETTLE)
            ) u_strobe_sync (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_async (w_raw[gi]),
                .o_sync  (w_sync[gi]),
                .o_stable(w_stable[gi])
            );
        end
    endgenerate

    assign w_cs_st = w_stable[0];
    assign w_we_st = w_stable[1];
    assign w_oe_st = w_stable[2];

    // Byte lanes travel with the address through the shadow register instead.
    assign w_unused_stb = &{1'b0, w_sync[4:3], w_sync[1], w_stable[4:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_addr  <= '0;
            r_sh_wdata <= '0;
            r_sh_be    <= '0;
            r_sh_ecc   <= '0;
            r_we_st_d  <= 1'b1;
        end else begin
            r_sh_addr  <= mcu_addr;
            r_sh_wdata <= mcu_wdata;
            r_sh_be    <= ~{mcu_ub_n, mcu_lb_n};
            r_sh_ecc   <= ecc_sel;
            r_we_st_d  <= w_we_st;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_req_valid   <= 1'b0;
            r_req_write   <= 1'b0;
            r_req_addr    <= '0;
            r_req_wdata   <= '0;
            r_req_be      <= '0;
            r_req_ecc     <= '0;
            r_rdata       <= '0;
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_cs_st && !w_we_st) begin
                        r_state <= ST_WR_ACTIVE;
                    end else if (!w_cs_st && !w_oe_st) begin
                        r_req_valid <= 1'b1;
                        r_req_write <= 1'b0;
                        r_req_addr  <= r_sh_addr;
                        r_req_wdata <= r_sh_wdata;
                        r_req_be    <= r_sh_be;
                        r_req_ecc   <= r_sh_ecc;
                        r_state     <= ST_RD_ISSUE;
                    end
                end
                ST_WR_ACTIVE: begin
                    if (w_we_st || w_cs_st) begin
                        r_req_valid <= 1'b1;
                        r_req_write <= 1'b1;
                        r_req_addr  <= r_sh_addr;
                        r_req_wdata <= r_sh_wdata;
                        r_req_be    <= r_sh_be;
                        r_req_ecc   <= r_sh_ecc;
                        r_state     <= ST_WR_ISSUE;
                    end
                end
                ST_WR_ISSUE: begin
                    // A fresh write strobe while the previous one is unaccepted is lost.
                    if (r_we_st_d && !w_we_st) begin
                        r_err_overrun <= 1'b1;
                    end
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_WAIT_END;
                    end
                end
                ST_RD_ISSUE: begin
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_to_cnt    <= '0;
                        r_state     <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_valid) begin
                        r_rdata <= rd_data;
                        r_state <= ST_RD_DRIVE;
                    end else if (w_cs_st || w_oe_st) begin
                        r_state <= ST_WAIT_END;
                    end else if (r_to_cnt == TO_W'(RD_TIMEOUT - 1)) begin
                        r_err_timeout <= 1'b1;
                        r_rdata       <= DATA_W'(DEAD_WORD);
                        r_state       <= ST_RD_DRIVE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_RD_DRIVE: begin
                    if (w_cs_st || w_oe_st) begin
                        r_state <= ST_WAIT_END;
                    end
                end
                ST_WAIT_END: begin
                    if (w_cs_st) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The pad enable follows the raw-synchronized strobes so it drops before the filter settles.
    assign mcu_rdata_oe = (r_state == ST_RD_DRIVE) && !w_sync[0] && !w_sync[2];
    assign mcu_rdata    = r_rdata;
    assign req_valid    = r_req_valid;
    assign req_write    = r_req_write;
    assign req_addr     = r_req_addr;
    assign req_wdata    = r_req_wdata;
    assign req_be       = r_req_be;
    assign req_ecc      = r_req_ecc;
    assign busy         = (r_state != ST_IDLE);
    assign err_timeout  = r_err_timeout;
    assign err_overrun  = r_err_overrun;

endmodule

`default_nettype wire
